// File: rtl/europa_sdm_dac_if.sv
// Sample-stream and status bundle of the delta-sigma audio DAC.
// The producer drives run control and samples; the DAC answers with readiness, bitstream and status.
interface europa_sdm_dac_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 enable;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 dac_out;
  logic                 sample_tick;
  logic                 underrun;
  logic [LW-1:0]        fifo_level;

  modport master (
    output enable,
    output in_data,
    output in_valid,
    input  in_ready,
    input  dac_out,
    input  sample_tick,
    input  underrun,
    input  fifo_level
  );

  modport slave (
    input  enable,
    input  in_data,
    input  in_valid,
    output in_ready,
    output dac_out,
    output sample_tick,
    output underrun,
    output fifo_level
  );

endinterface

// File: rtl/europa_sdm_dac.sv
// First-order delta-sigma audio DAC: a small sample FIFO drained once per sample period
// into a held register that feeds a carry-out modulator running every clock.
module europa_sdm_dac #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 750
) (
  input  logic             clk,
  input  logic             reset,
  europa_sdm_dac_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] held_q, held_d;
  logic [DATA_BITS:0]   acc_q, acc_d;
  logic [DATA_BITS:0]   sum_s;
  logic                 tick_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 underrun_s;

  // Event decode: pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    tick_s     = bus.enable && (cnt_q == CNT_LAST);
    push_s     = bus.in_valid && (level_q != LVL_FULL);
    pop_s      = tick_s && (level_q != LVL_ZERO);
    underrun_s = tick_s && (level_q == LVL_ZERO);
  end

  // Sample-period counter, parked at zero while stopped.
  always_comb begin
    cnt_d = {CW{1'b0}};
    if (!bus.enable) begin
      cnt_d = {CW{1'b0}};
    end else if (tick_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // FIFO bookkeeping; a push on a tick into an empty FIFO is not visible to that tick.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    held_d   = held_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      held_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      held_d   = held_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Modulator: the carry out of the low DATA_BITS is the next output bit.
  always_comb begin
    sum_s = {1'b0, acc_q[DATA_BITS-1:0]} + {1'b0, held_q};
    acc_d = {(DATA_BITS+1){1'b0}};
    if (bus.enable) begin
      acc_d = sum_s;
    end else begin
      acc_d = {(DATA_BITS+1){1'b0}};
    end
  end

  // Control and datapath state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      cnt_q    <= {CW{1'b0}};
      held_q   <= {DATA_BITS{1'b0}};
      acc_q    <= {(DATA_BITS+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      acc_q    <= acc_d;
    end
  end

  // Sample storage; entries are only ever read behind a valid occupancy count.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready    = (level_q != LVL_FULL);
  assign bus.fifo_level  = level_q;
  assign bus.dac_out     = acc_q[DATA_BITS];
  assign bus.sample_tick = tick_s;
  assign bus.underrun    = underrun_s;

endmodule
